i2c_target_reg_bank: RTL and testbench

//   Parametrised I2C target (slave) with an internal register bank of NUM_REGS x 8 bits.
//   It succeeds the fixed-size SPI/I2C register bank: configurable depth, target address and input glitch filter,
//   and it adds a register pointer, repeated-START handling, range checking and write notification.

---
 rtl/i2c_target_reg_bank.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_target_reg_bank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_reg_bank.sv
// I2C target with a NUM_REGS x 8 register bank, register pointer and write strobe.
// Optional feature: define I2C_AUTO_INC_EN to advance the pointer after each data byte.

module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    logic [1:0] sync;
    logic [3:0] cnt;

    // A new level is accepted only once the synced input has held it for FILTER_LEN clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == 4'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module i2c_target_reg_bank #(
    parameter logic [6:0] I2C_ADDR   = 7'h70,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_pulse_o,
    output logic [PTR_W-1:0]      wr_addr_o,
    output logic                  busy_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
    } state_t;

    state_t           state, state_n;
    logic [1:0]       line_raw, line_filt;
    logic             scl_f, sda_f, scl_q, sda_q;
    logic             start, stop, scl_rise, scl_fall;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       rx_byte, rx_byte_n, tx_byte, tx_byte_n;
    logic [PTR_W-1:0] ptr, ptr_n, ptr_inc, ptr_adv;
    logic             rw, rw_n, mack, mack_n;
    logic             sda_oe_n, busy_n, wr_en;
    logic [7:0]       mem [NUM_REGS];

    assign line_raw = {scl_i, sda_i};
    for (genvar i = 0; i < 2; i++) begin : g_filt
        i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk  (clk),
            .rst  (rst),
            .raw  (line_raw[i]),
            .filt (line_filt[i])
        );
    end
    assign {scl_f, sda_f} = line_filt;

    assign start    = scl_f & scl_q & sda_q & ~sda_f;
    assign stop     = scl_f & scl_q & ~sda_q & sda_f;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;

    assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);
`ifdef I2C_AUTO_INC_EN
    assign ptr_adv = ptr_inc;
`else
    assign ptr_adv = ptr;
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign regs_o[8*k +: 8] = mem[k];
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rx_byte_n = rx_byte;
        tx_byte_n = tx_byte;
        ptr_n     = ptr;
        rw_n      = rw;
        mack_n    = mack;
        sda_oe_n  = sda_oe;
        busy_n    = busy_o;
        wr_en     = 1'b0;
        if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WDATA:
                    if (bit_cnt != 4'd8) begin
                        rx_byte_n = {rx_byte[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                RDATA:
                    if (bit_cnt != 4'd8) bit_cnt_n = bit_cnt + 4'd1;
                RDATA_MACK: mack_n = sda_f;
                default: ;
            endcase
        end else if (scl_fall) begin
            // All SDA output changes happen here, while SCL is low.
            case (state)
                ADDR:
                    if (bit_cnt == 4'd8) begin
                        if (rx_byte[7:1] == I2C_ADDR) begin
                            state_n  = ADDR_ACK;
                            rw_n     = rx_byte[0];
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                ADDR_ACK: begin
                    bit_cnt_n = '0;
                    if (rw) begin
                        state_n   = RDATA;
                        tx_byte_n = mem[ptr];
                        sda_oe_n  = ~mem[ptr][7];
                    end else begin
                        state_n  = PTR;
                        sda_oe_n = 1'b0;
                    end
                end
                PTR:
                    if (bit_cnt == 4'd8) begin
                        if (int'(rx_byte) < NUM_REGS) begin
                            ptr_n    = rx_byte[PTR_W-1:0];
                            sda_oe_n = 1'b1;
                            state_n  = PTR_ACK;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                PTR_ACK: begin
                    sda_oe_n  = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = WDATA;
                end
                WDATA:
                    if (bit_cnt == 4'd8) begin
                        wr_en    = 1'b1;
                        sda_oe_n = 1'b1;
                        state_n  = WDATA_ACK;
                    end
                WDATA_ACK: begin
                    sda_oe_n  = 1'b0;
                    bit_cnt_n = '0;
                    ptr_n     = ptr_adv;
                    state_n   = WDATA;
                end
                RDATA:
                    if (bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        state_n  = RDATA_MACK;
                    end else begin
                        tx_byte_n = {tx_byte[6:0], 1'b0};
                        sda_oe_n  = ~tx_byte[6];
                    end
                RDATA_MACK:
                    if (!mack) begin
                        ptr_n     = ptr_adv;
                        tx_byte_n = mem[ptr_adv];
                        sda_oe_n  = ~mem[ptr_adv][7];
                        bit_cnt_n = '0;
                        state_n   = RDATA;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            tx_byte    <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            mack       <= 1'b1;
            sda_oe     <= 1'b0;
            busy_o     <= 1'b0;
            wr_pulse_o <= 1'b0;
            wr_addr_o  <= '0;
        end else begin
            state      <= state_n;
            scl_q      <= scl_f;
            sda_q      <= sda_f;
            bit_cnt    <= bit_cnt_n;
            rx_byte    <= rx_byte_n;
            tx_byte    <= tx_byte_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            mack       <= mack_n;
            sda_oe     <= sda_oe_n;
            busy_o     <= busy_n;
            wr_pulse_o <= wr_en;
            if (wr_en) wr_addr_o <= ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
        end else if (wr_en) begin
            mem[ptr] <= rx_byte;
        end
    end
endmodule

// File: tb/tb_i2c_target_reg_bank.sv
// Randomized I2C master driving the register bank, checked against a transaction-level model.
module tb_i2c_target_reg_bank;
    localparam int NUM_REGS = 16;
    localparam int PTR_W    = 4;
    localparam int Q        = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1;
    logic sda_line;
    logic sda_oe, wr_pulse_o, busy_o;
    logic [NUM_REGS*8-1:0] regs_o;
    logic [PTR_W-1:0] wr_addr_o;

    typedef struct packed { logic [7:0] idx; logic [7:0] data; } wr_t;

    int errors = 0, checks = 0;
    logic [7:0] mdl [NUM_REGS];
    logic [7:0] shadow [NUM_REGS];
    logic [NUM_REGS*8-1:0] exp_flat;
    int m_ptr = 0;
    wr_t exp_q[$];
    logic [7:0] wdat[$];
    logic [7:0] rd_bytes[$];
    int pulse_cnt = 0;
    bit prev_pulse = 0;
    bit oe_seen = 0;

    assign sda_line = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_target_reg_bank dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o),
        .wr_addr_o  (wr_addr_o),
        .busy_o     (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int adv(input int p);
`ifdef I2C_AUTO_INC_EN
        return (p + 1) % NUM_REGS;
`else
        return p;
`endif
    endfunction

    // Every cycle: committed writes must match the expected write list and the bank must match.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) shadow[k] = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (wr_pulse_o) begin
                pulse_cnt++;
                chk("wr_pulse_width", 32'(prev_pulse), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: wr_addr_o=%0d, no write was due", wr_addr_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr_o), 32'(e.idx));
                    shadow[e.idx] = e.data;
                end
            end
            prev_pulse = wr_pulse_o;
            for (int k = 0; k < NUM_REGS; k++) exp_flat[8*k +: 8] = shadow[k];
            checks++;
            if (regs_o !== exp_flat) begin
                errors++;
                $display("FAIL regs_bank: got %h, expected %h", regs_o, exp_flat);
            end
        end
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; entered and left just after SCL falls.
    task automatic bus_bit(input logic v, input bit gl, output logic r);
        w(Q/2);
        if (gl) begin scl_m = 1'b1; w(1); scl_m = 1'b0; end
        w(Q/2);
        sda_m = v;
        w(Q);
        scl_m = 1'b1;
        w(Q/2);
        r = sda_line;
        if (gl && v) begin sda_m = 1'b0; w(1); sda_m = 1'b1; end
        w(Q/2);
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            w(Q); sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q);
        end
        sda_m = 1'b0; w(Q); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        w(Q); sda_m = 1'b0; w(Q); scl_m = 1'b1; w(Q); sda_m = 1'b1; w(2*Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit gl, output bit ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], gl, r);
        bus_bit(1'b1, 1'b0, r);
        ack = !r;
    endtask

    task automatic rd_byte(input bit mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            b[i] = r;
        end
        bus_bit(mack ? 1'b0 : 1'b1, 1'b0, r);
    endtask

    // Data bytes come from wdat.
    task automatic txn_write(input logic [7:0] ab, input int p, input bit gl);
        bit ack, exp_a, act;
        oe_seen = 1'b0;
        bus_start();
        wr_byte(ab, gl, ack);
        exp_a = (ab[7:1] == 7'h70) && !ab[0];
        chk("wr_addr_ack", 32'(ack), 32'(exp_a));
        chk("busy_after_addr", 32'(busy_o), 32'(exp_a));
        wr_byte(8'(p), gl, ack);
        act = exp_a && (p < NUM_REGS);
        chk("wr_ptr_ack", 32'(ack), 32'(act));
        chk("busy_after_ptr", 32'(busy_o), 32'(act));
        if (act) m_ptr = p;
        foreach (wdat[i]) begin
            if (act) begin
                exp_q.push_back({8'(m_ptr), wdat[i]});
                mdl[m_ptr] = wdat[i];
            end
            wr_byte(wdat[i], gl, ack);
            chk("wr_data_ack", 32'(ack), 32'(act));
            if (act) m_ptr = adv(m_ptr);
        end
        bus_stop();
        w(4);
        chk("busy_after_stop", 32'(busy_o), 0);
        chk("writes_committed", 32'(exp_q.size()), 0);
        if (!exp_a) chk("no_drive_wrong_addr", 32'(oe_seen), 0);
    endtask

    task automatic txn_read(input int p, input int n);
        bit ack, ok, mack;
        logic [7:0] b;
        rd_bytes.delete();
        bus_start();
        wr_byte(8'hE0, 1'b0, ack);
        chk("rd_addr_ack", 32'(ack), 1);
        wr_byte(8'(p), 1'b0, ack);
        ok = (p < NUM_REGS);
        chk("rd_ptr_ack", 32'(ack), 32'(ok));
        if (ok) begin
            m_ptr = p;
            bus_start();
            wr_byte(8'hE1, 1'b0, ack);
            chk("rd_addr_ack_r", 32'(ack), 1);
            for (int j = 0; j < n; j++) begin
                mack = (j < n - 1);
                rd_byte(mack, b);
                rd_bytes.push_back(b);
                chk("rd_data", 32'(b), 32'(mdl[m_ptr]));
                if (mack) m_ptr = adv(m_ptr);
            end
            oe_seen = 1'b0;
        end
        bus_stop();
        w(4);
        if (ok) chk("no_drive_after_nack", 32'(oe_seen), 0);
        chk("busy_after_stop", 32'(busy_o), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        bit ack;
        logic r;
        for (int k = 0; k < NUM_REGS; k++) mdl[k] = 8'h00;
        w(4);
        #1 rst = 1'b0;
        w(3);
        chk("reset_sda_oe", 32'(sda_oe), 0);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_wr_pulse", 32'(wr_pulse_o), 0);
        chk("reset_regs_zero", 32'(regs_o == '0), 1);

        // S E0 03 A5 P
        p0 = pulse_cnt;
        wdat = {8'hA5};
        txn_write(8'hE0, 3, 1'b0);
        chk("lit_reg3", 32'(regs_o[3*8 +: 8]), 32'hA5);
        chk("lit_single_pulse", 32'(pulse_cnt - p0), 1);
        chk("lit_wr_addr", 32'(wr_addr_o), 3);

        // S E0 0F 11 22 P
        wdat = {8'h11, 8'h22};
        txn_write(8'hE0, 15, 1'b0);
`ifdef I2C_AUTO_INC_EN
        chk("lit_reg15", 32'(regs_o[15*8 +: 8]), 32'h11);
        chk("lit_reg0", 32'(regs_o[0 +: 8]), 32'h22);
`else
        chk("lit_reg15", 32'(regs_o[15*8 +: 8]), 32'h22);
`endif

        // S E0 03 Sr E1 rd ACK rd NACK P
        txn_read(3, 2);
        chk("lit_rd0", 32'(rd_bytes[0]), 32'hA5);
`ifdef I2C_AUTO_INC_EN
        chk("lit_rd1", 32'(rd_bytes[1]), 32'h00);
`else
        chk("lit_rd1", 32'(rd_bytes[1]), 32'hA5);
`endif

        // Wrong address, then out-of-range pointer
        wdat = {8'h5A};
        txn_write(8'hE2, 1, 1'b0);
        p0 = pulse_cnt;
        wdat = {8'h77};
        txn_write(8'hE0, 32, 1'b0);
        chk("lit_no_write_bad_ptr", 32'(pulse_cnt - p0), 0);

        // Glitches on both lines
        wdat = {8'h3C};
        txn_write(8'hE0, 5, 1'b1);
        chk("lit_reg5_glitch", 32'(regs_o[5*8 +: 8]), 32'h3C);

        // STOP after 4 data bits
        p0 = pulse_cnt;
        bus_start();
        wr_byte(8'hE0, 1'b0, ack);
        wr_byte(8'h06, 1'b0, ack);
        m_ptr = 6;
        for (int i = 0; i < 4; i++) bus_bit(i[0], 1'b0, r);
        bus_stop();
        w(4);
        chk("stop_midbyte_no_write", 32'(pulse_cnt - p0), 0);
        chk("stop_midbyte_busy", 32'(busy_o), 0);

        // Random traffic
        for (int t = 0; t < 24; t++) begin
            int kind, p, n;
            logic [6:0] a;
            kind = $urandom_range(0, 9);
            p = $urandom_range(0, NUM_REGS - 1);
            n = $urandom_range(1, 3);
            wdat.delete();
            for (int i = 0; i < n; i++) wdat.push_back(8'($urandom));
            if (kind == 0) begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h70) a = 7'h71;
                txn_write({a, 1'b0}, p, 1'b0);
            end else if (kind == 1) begin
                txn_write(8'hE0, $urandom_range(NUM_REGS, 255), 1'b0);
            end else if (kind < 6) begin
                txn_write(8'hE0, p, kind == 5);
            end else begin
                txn_read(p, n);
            end
        end

        // rst pulse mid-read of a register holding 0x00 (target is pulling SDA low)
        wdat = {8'h00};
        txn_write(8'hE0, 2, 1'b0);
        bus_start();
        wr_byte(8'hE0, 1'b0, ack);
        wr_byte(8'h02, 1'b0, ack);
        bus_start();
        wr_byte(8'hE1, 1'b0, ack);
        bus_bit(1'b1, 1'b0, r);
        bus_bit(1'b1, 1'b0, r);
        w(Q/2);
        chk("oe_before_rst", 32'(sda_oe), 1);
        #1 rst = 1'b1;
        w(1);
        chk("oe_after_rst", 32'(sda_oe), 0);
        chk("busy_after_rst", 32'(busy_o), 0);
        chk("regs_after_rst", 32'(regs_o == '0), 1);
        #1 rst = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) mdl[k] = 8'h00;
        m_ptr = 0;
        exp_q.delete();
        bus_stop();
        w(4);
        txn_read(2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
